vram_dma: RTL and testbench



---
 rtl/gpu_dma_pkg.sv | 15 +
 rtl/dma_fifo.sv | 55 +++++
 rtl/vram_dma.sv | 136 +++++++++++++
 tb/tb_vram_dma.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_dma_pkg.sv
// Shared types and VRAM map constants for the VRAM DMA engine.
// Holds the engine state enum and the VRAM region base addresses.
package gpu_dma_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam logic [11:0] PMB_BASE  = 12'h200;
  localparam logic [11:0] NTBL_BASE = 12'h400;
  localparam logic [11:0] VRAM_END  = 12'h800;

endpackage

// File: rtl/dma_fifo.sv
// Synchronous FIFO between memory reads and VRAM writes.
// Ports: clk, rst (sync, active-low), push/wdata, pop, full, empty, head.
module dma_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rp;
  logic [AW-1:0]    wp;
  logic [AW:0]      cnt;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign head    = mem[rp];
  // A pop frees the slot the same edge, so push on full is fine then.
  assign do_push = push & (~full | pop);
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (!rst) begin
      rp  <= '0;
      wp  <= '0;
      cnt <= '0;
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wp] <= wdata;
        wp      <= wp + 1'b1;
      end
      if (do_pop)
        rp <= rp + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/vram_dma.sv
// Copy engine: reads system memory, writes VRAM in the writable window.
// Ports: clk, rst (sync, active-low), start/src_addr/dst_addr/length,
// busy, done, mem_req/mem_addr/mem_ack/mem_rdata, writable,
// address/data_out/write_enable. VRAM_DMA_FILL_EN adds fill/fill_value.
module vram_dma
  import gpu_dma_pkg::*;
#(
  parameter int VRAM_ADDR_WIDTH = 12,
  parameter int SRC_ADDR_WIDTH  = 16,
  parameter int LEN_WIDTH       = 12,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [SRC_ADDR_WIDTH-1:0]  src_addr,
  input  logic [VRAM_ADDR_WIDTH-1:0] dst_addr,
  input  logic [LEN_WIDTH-1:0]       length,
`ifdef VRAM_DMA_FILL_EN
  input  logic                       fill,
  input  logic [7:0]                 fill_value,
`endif
  output logic                       busy,
  output logic                       done,
  output logic                       mem_req,
  output logic [SRC_ADDR_WIDTH-1:0]  mem_addr,
  input  logic                       mem_ack,
  input  logic [7:0]                 mem_rdata,
  input  logic                       writable,
  output logic [VRAM_ADDR_WIDTH-1:0] address,
  output logic [7:0]                 data_out,
  output logic                       write_enable
);

  state_t                     state;
  state_t                     state_n;
  logic [SRC_ADDR_WIDTH-1:0]  src_q;
  logic [VRAM_ADDR_WIDTH-1:0] dst_q;
  logic [LEN_WIDTH-1:0]       len_q;
  logic [LEN_WIDTH-1:0]       rd_cnt;
  logic [LEN_WIDTH-1:0]       wr_cnt;
  logic                       run;
  logic                       push;
  logic                       pop;
  logic                       full;
  logic                       empty;
  logic [7:0]                 head;
  logic                       wr_last;
  logic                       fill_mode;
  logic [7:0]                 fill_byte;

`ifdef VRAM_DMA_FILL_EN
  logic       fill_q;
  logic [7:0] fval_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      fill_q <= 1'b0;
      fval_q <= '0;
    end else if (state == IDLE && start) begin
      fill_q <= fill;
      fval_q <= fill_value;
    end
  end

  assign fill_mode = fill_q;
  assign fill_byte = fval_q;
`else
  assign fill_mode = 1'b0;
  assign fill_byte = '0;
`endif

  assign run      = (state == RUN);
  assign busy     = run;
  assign done     = (state == DONE);
  assign mem_addr = src_q;
  // The request stays up until ack: full and rd_cnt only move on ack.
  assign mem_req  = run & ~fill_mode & (rd_cnt != len_q) & ~full;
  assign push     = mem_req & mem_ack;
  assign write_enable = run & writable & (fill_mode | ~empty);
  assign pop      = write_enable & ~fill_mode;
  assign address  = dst_q + VRAM_ADDR_WIDTH'(wr_cnt);
  assign data_out = fill_mode ? fill_byte : head;
  assign wr_last  = ((wr_cnt + LEN_WIDTH'(1)) == len_q);

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (start) state_n = (length != '0) ? RUN : DONE;
      RUN:  if (write_enable && wr_last) state_n = DONE;
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      src_q  <= '0;
      dst_q  <= '0;
      len_q  <= '0;
      rd_cnt <= '0;
      wr_cnt <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && start) begin
        src_q  <= src_addr;
        dst_q  <= dst_addr;
        len_q  <= length;
        rd_cnt <= '0;
        wr_cnt <= '0;
      end
      if (push) begin
        rd_cnt <= rd_cnt + 1'b1;
        src_q  <= src_q + 1'b1;
      end
      if (write_enable)
        wr_cnt <= wr_cnt + 1'b1;
    end
  end

  dma_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (mem_rdata),
    .full  (full),
    .empty (empty),
    .head  (head)
  );

endmodule

// File: tb/tb_vram_dma.sv
// Directed bench for vram_dma: transfer table plus corner sequences.
// Memory model returns a fixed function of the read address.
module tb_vram_dma;

  localparam int FD = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] src_addr = '0;
  logic [11:0] dst_addr = '0;
  logic [11:0] length = '0;
`ifdef VRAM_DMA_FILL_EN
  logic        fill = 1'b0;
  logic [7:0]  fill_value = '0;
`endif
  logic        busy, done, mem_req, write_enable;
  logic [15:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [7:0]  mem_rdata = '0;
  logic        writable = 1'b0;
  logic [11:0] address;
  logic [7:0]  data_out;

  always #5 clk = ~clk;

  vram_dma #(
    .VRAM_ADDR_WIDTH (12),
    .SRC_ADDR_WIDTH  (16),
    .LEN_WIDTH       (12),
    .FIFO_DEPTH      (FD)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .src_addr     (src_addr),
    .dst_addr     (dst_addr),
    .length       (length),
`ifdef VRAM_DMA_FILL_EN
    .fill         (fill),
    .fill_value   (fill_value),
`endif
    .busy         (busy),
    .done         (done),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata),
    .writable     (writable),
    .address      (address),
    .data_out     (data_out),
    .write_enable (write_enable)
  );

  function automatic logic [7:0] f(input logic [15:0] a);
    return a[7:0] ^ {a[11:8], 4'h0};
  endfunction

  typedef struct {
    logic [15:0] src;
    logic [11:0] dst;
    logic [11:0] len;
    int          on_c;
    int          off_c;
    int          dly;
    bit          spur;
    logic [11:0] exp_first;
    logic [11:0] exp_last;
    int          exp_occ;
  } vec_t;

  int checks = 0;
  int errors = 0;

  bit          mon_on = 1'b0;
  logic [11:0] wr_a[$];
  logic [7:0]  wr_d[$];
  logic [15:0] rd_a[$];
  int n_done, n_busy_done, n_req, n_unstable, n_we_closed, occ_max;
  int on_c = 1, off_c = 0, dly = 0, phase = 0, wcnt = 0;
  bit spur = 1'b0;
  logic        prev_req = 1'b0, prev_ack = 1'b0;
  logic [15:0] prev_addr = '0;

  always @(negedge clk) begin
    if (off_c == 0) writable = 1'b1;
    else begin
      writable = (phase < on_c);
      phase = (phase + 1) % (on_c + off_c);
    end
    if (mem_req === 1'b1) begin
      if (wcnt >= dly) begin
        mem_ack = 1'b1;
        mem_rdata = f(mem_addr);
        wcnt = 0;
      end else begin
        mem_ack = 1'b0;
        wcnt++;
      end
    end else begin
      wcnt = 0;
      mem_ack = spur;
      mem_rdata = 8'hEE;
    end
    #1;
    if (mon_on) begin
      if (write_enable) begin
        wr_a.push_back(address);
        wr_d.push_back(data_out);
        if (!writable) n_we_closed++;
      end
      if (mem_req) begin
        n_req++;
        if (prev_req && !prev_ack && mem_addr != prev_addr)
          n_unstable++;
        if (mem_ack) rd_a.push_back(mem_addr);
      end
      if (done) begin
        n_done++;
        if (busy) n_busy_done++;
      end
      if (rd_a.size() - wr_a.size() > occ_max)
        occ_max = rd_a.size() - wr_a.size();
    end
    prev_req = mem_req;
    prev_ack = mem_ack;
    prev_addr = mem_addr;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic launch(input logic [15:0] s, input logic [11:0] d,
                        input logic [11:0] l);
    wr_a.delete();
    wr_d.delete();
    rd_a.delete();
    n_done = 0; n_busy_done = 0; n_req = 0;
    n_unstable = 0; n_we_closed = 0; occ_max = 0;
    phase = 0;
    mon_on = 1'b1;
    @(negedge clk);
    src_addr = s; dst_addr = d; length = l; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int c = 0;
    while (n_done == 0 && c < budget) begin
      @(negedge clk);
      c++;
    end
    chk("done_timeout", 32'(c < budget), 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_log(input string nm, input logic [15:0] s,
                           input logic [11:0] d, input int l,
                           input bit reads);
    int bad = 0;
    chk({nm, "_wcount"}, 32'(wr_a.size()), 32'(l));
    for (int i = 0; i < wr_a.size(); i++) begin
      if (wr_a[i] !== d + 12'(i)) bad++;
      if (wr_d[i] !== f(s + 16'(i))) bad++;
    end
    chk({nm, "_wbad"}, 32'(bad), 0);
    chk({nm, "_done"}, 32'(n_done), 1);
    chk({nm, "_busy_at_done"}, 32'(n_busy_done), 0);
    chk({nm, "_we_closed"}, 32'(n_we_closed), 0);
    if (reads) begin
      bad = 0;
      chk({nm, "_rcount"}, 32'(rd_a.size()), 32'(l));
      for (int i = 0; i < rd_a.size(); i++)
        if (rd_a[i] !== s + 16'(i)) bad++;
      chk({nm, "_rbad"}, 32'(bad), 0);
      chk({nm, "_unstable"}, 32'(n_unstable), 0);
    end
  endtask

  vec_t vecs[4];

  initial begin
    vecs[0] = '{16'h1000, 12'h200, 12'd16, 1, 0, 0, 1'b0,
                12'h200, 12'h20F, 0};
    vecs[1] = '{16'h2000, 12'h400, 12'd64, 4, 20, 0, 1'b1,
                12'h400, 12'h43F, FD};
    vecs[2] = '{16'hFFFF, 12'hFFE, 12'd4, 1, 0, 3, 1'b0,
                12'hFFE, 12'h001, 0};
    vecs[3] = '{16'h0ABC, 12'h7F0, 12'd20, 1, 1, 1, 1'b0,
                12'h7F0, 12'h803, 0};

    rst = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_we", 32'(write_enable), 0);
    chk("rst_address", 32'(address), 0);
    chk("rst_data_out", 32'(data_out), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    rst = 1'b1;

    for (int k = 0; k < 4; k++) begin
      on_c = vecs[k].on_c;
      off_c = vecs[k].off_c;
      dly = vecs[k].dly;
      spur = vecs[k].spur;
      launch(vecs[k].src, vecs[k].dst, vecs[k].len);
      wait_done(int'(vecs[k].len) * 40 + 100);
      spur = 1'b0;
      check_log($sformatf("vec%0d", k), vecs[k].src, vecs[k].dst,
                int'(vecs[k].len), 1'b1);
      chk($sformatf("vec%0d_first", k), 32'(wr_a[0]),
          32'(vecs[k].exp_first));
      chk($sformatf("vec%0d_last", k), 32'(wr_a[wr_a.size()-1]),
          32'(vecs[k].exp_last));
      if (vecs[k].exp_occ != 0)
        chk($sformatf("vec%0d_occ_max", k), 32'(occ_max),
            32'(vecs[k].exp_occ));
    end

    // zero-length transfer
    on_c = 1; off_c = 0; dly = 0;
    launch(16'h1234, 12'h250, 12'd0);
    #2;
    chk("zl_done", 32'(done), 1);
    chk("zl_busy", 32'(busy), 0);
    @(negedge clk);
    #2;
    chk("zl_done_drop", 32'(done), 0);
    repeat (3) @(negedge clk);
    chk("zl_req", 32'(n_req), 0);
    chk("zl_writes", 32'(wr_a.size()), 0);
    chk("zl_done_count", 32'(n_done), 1);

    // second start while running is ignored
    on_c = 0; off_c = 1;
    launch(16'h3000, 12'h300, 12'd8);
    repeat (6) @(negedge clk);
    src_addr = 16'h5000; dst_addr = 12'h500; length = 12'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    on_c = 1; off_c = 0;
    wait_done(400);
    check_log("ign", 16'h3000, 12'h300, 8, 1'b1);

    // reset in the middle of a transfer
    begin
      int c = 0;
      launch(16'h4000, 12'h600, 12'd32);
      while (wr_a.size() < 5 && c < 200) begin
        @(negedge clk);
        c++;
      end
      chk("mid_reach5", 32'(c < 200), 1);
      rst = 1'b0;
      @(negedge clk);
      #2;
      chk("mid_rst_outs",
          {8'h0, busy, done, mem_req, write_enable, address, data_out},
          32'h0);
      chk("mid_rst_mem_addr", 32'(mem_addr), 0);
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("mid_no_done", 32'(n_done), 0);
      launch(16'h4400, 12'h680, 12'd8);
      wait_done(400);
      check_log("fresh", 16'h4400, 12'h680, 8, 1'b1);
    end

`ifdef VRAM_DMA_FILL_EN
    begin
      int bad = 0;
      fill = 1'b1;
      fill_value = 8'hA5;
      launch(16'h0000, 12'h400, 12'd960);
      fill = 1'b0;
      wait_done(2000);
      chk("fill_count", 32'(wr_a.size()), 960);
      for (int i = 0; i < wr_a.size(); i++) begin
        if (wr_a[i] !== 12'h400 + 12'(i)) bad++;
        if (wr_d[i] !== 8'hA5) bad++;
      end
      chk("fill_bad", 32'(bad), 0);
      chk("fill_last", 32'(wr_a[wr_a.size()-1]), 32'h7BF);
      chk("fill_req", 32'(n_req), 0);
      chk("fill_done", 32'(n_done), 1);
    end
`endif

    mon_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
